// File: rtl/ps2_kb_pkg.sv
// ----------------------------------------------------------------------------
// ps2_kb_pkg
// Shared definitions for the PS/2 keyboard event sequencer:
//   - scan-code prefix bytes (E0 extended, F0 break)
//   - sequencer state encoding
//   - key-event record, packed as {ext, brk, code[7:0]} (EV_W bits)
// ----------------------------------------------------------------------------
package ps2_kb_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  localparam int EV_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GOT_E0 = 2'b01,
    GOT_F0 = 2'b10
  } kb_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kb_event_t;

  // True for either prefix byte; such bytes never produce an event by themselves.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT_PREFIX) || (b == PS2_BRK_PREFIX);
  endfunction

endpackage

// File: rtl/ps2_kb_fifo.sv
// ----------------------------------------------------------------------------
// ps2_kb_fifo
// Synchronous FIFO holding key events.
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   push_i      : write din_i this cycle; caller only asserts it when the entry
//                 fits (not full, or full with a pop in the same cycle)
//   din_i       : event to write
//   pop_i       : discard the head entry (ignored while empty)
//   dout_o      : head entry (entry at the read pointer)
//   full_o      : count == FIFO_DEPTH
//   empty_o     : count == 0
//   count_o     : number of stored entries, FIFO_AW+1 bits
// ----------------------------------------------------------------------------
module ps2_kb_fifo
  import ps2_kb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [EV_W-1:0]   din_i,
  input  logic              pop_i,
  output logic [EV_W-1:0]   dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [FIFO_AW:0]  count_o
);

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [EV_W-1:0]    mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               rd_en;

  assign rd_en   = pop_i & ~empty_o;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; the read side never trusts an entry until
  // count says it was written, so clearing it would only cost flops.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kb_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_kb_ctrl
// Sequencer behind a PS/2 receiver: folds scan-code sequences (plain, F0 xx,
// E0 xx, E0 F0 xx) into single key events and queues them for a consumer.
//   clk, reset    : clock, asynchronous active-high reset
//   rx_done_tick  : receiver strobe, rx_dout valid in that cycle
//   rx_dout       : received byte
//   rx_en         : receive enable, high while the event FIFO has room
//   ev_valid      : head event present
//   ev_ready      : consumer takes the head event when ev_valid & ev_ready
//   ev_code       : head event scan code
//   ev_break      : head event is a key release
//   ev_ext        : head event carried the E0 prefix
//   ovf           : sticky, an event was dropped because the FIFO was full
//   ovf_clr       : clears ovf (a same-cycle set wins)
// Build option: define PS2_KB_TIMEOUT_EN to abandon a prefix sequence that
// sees no further byte within TIMEOUT_CYC cycles. Without it the prefix
// states wait indefinitely.
// ----------------------------------------------------------------------------
module ps2_kb_ctrl
  import ps2_kb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FIFO_AW     = $clog2(FIFO_DEPTH),
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  output logic       rx_en,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       ovf,
  input  logic       ovf_clr
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      (1 << FIFO_AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("ps2_kb_ctrl: FIFO_DEPTH must be a power of two >= 2 equal to 2**FIFO_AW");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("ps2_kb_ctrl: TIMEOUT_CYC must be >= 2");
  end

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

  kb_state_e        state_q;
  logic             ext_q;
  logic             brk_q;
  logic             ovf_q;

  logic             push_req;
  logic             push_ok;
  logic             pop;
  kb_event_t        push_ev;
  kb_event_t        head_ev;
  logic [EV_W-1:0]  fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;

`ifdef PS2_KB_TIMEOUT_EN
  localparam int              TMO_W   = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  // Any non-prefix byte completes a sequence. The flags already encode the
  // prefix history: ext_q is set only after E0, brk_q only in GOT_F0, and both
  // are clear in IDLE, so they form the event fields directly.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    pop          = ~fifo_empty & ev_ready;
    push_req     = rx_done_tick & ~is_prefix(rx_dout);
    push_ev      = '0;
    push_ev.ext  = ext_q;
    push_ev.brk  = brk_q;
    push_ev.code = rx_dout;
    // A full FIFO still accepts when its head leaves in the same cycle.
    push_ok      = push_req & (~fifo_full | pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
`ifdef PS2_KB_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else if (rx_done_tick) begin
`ifdef PS2_KB_TIMEOUT_EN
      tmo_q <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (rx_dout == PS2_EXT_PREFIX) begin
            state_q <= GOT_E0;
            ext_q   <= 1'b1;
          end else if (rx_dout == PS2_BRK_PREFIX) begin
            state_q <= GOT_F0;
            brk_q   <= 1'b1;
          end
        end
        GOT_E0: begin
          if (rx_dout == PS2_BRK_PREFIX) begin
            state_q <= GOT_F0;
            brk_q   <= 1'b1;
          end else if (rx_dout == PS2_EXT_PREFIX) begin
            ext_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
          end
        end
        GOT_F0: begin
          if (rx_dout == PS2_EXT_PREFIX) begin
            // E0 after F0 is a protocol error: restart as a fresh extended code.
            state_q <= GOT_E0;
            ext_q   <= 1'b1;
            brk_q   <= 1'b0;
          end else if (rx_dout != PS2_BRK_PREFIX) begin
            state_q <= IDLE;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ext_q   <= 1'b0;
          brk_q   <= 1'b0;
        end
      endcase
    end
`ifdef PS2_KB_TIMEOUT_EN
    else if (state_q != IDLE) begin
      if (tmo_q == TMO_MAX) begin
        // Stale prefix: drop it silently.
        state_q <= IDLE;
        ext_q   <= 1'b0;
        brk_q   <= 1'b0;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end else begin
      tmo_q <= '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (push_req & ~push_ok) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  ps2_kb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_ok),
    .din_i   (push_ev),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_ev  = fifo_dout;
  assign ev_valid = ~fifo_empty;
  assign ev_code  = head_ev.code;
  assign ev_break = head_ev.brk;
  assign ev_ext   = head_ev.ext;
  assign ovf      = ovf_q;
  // Deasserts the moment the FIFO fills; a frame already underway may still
  // land and overflow.
  assign rx_en    = (fifo_count < DEPTH_C);

endmodule

// File: tb/tb_ps2_kb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_kb_ctrl
// Scoreboard bench for ps2_kb_ctrl (FIFO_DEPTH=4, TIMEOUT_CYC=16). Stimulus
// pushes the expected event before sending the completing byte; a monitor
// pops and compares on every accepted handshake. Expectations for the
// timeout case follow PS2_KB_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_ps2_kb_ctrl;
  import ps2_kb_pkg::*;

  logic       clk          = 1'b0;
  logic       reset        = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout      = 8'h00;
  logic       ev_ready     = 1'b0;
  logic       ovf_clr      = 1'b0;
  logic       rx_en;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic       ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [EV_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  ps2_kb_ctrl #(
    .FIFO_DEPTH  (4),
    .FIFO_AW     (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .rx_en        (rx_en),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_code      (ev_code),
    .ev_break     (ev_break),
    .ev_ext       (ev_ext),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr)
  );

  function automatic logic [EV_W-1:0] ev(input logic e, input logic b, input logic [7:0] c);
    return {e, b, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One receiver strobe, inputs changed just after the edge.
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done_tick = 1'b1;
    rx_dout      = b;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_event: got %h, none expected", {ev_ext, ev_break, ev_code});
      end else begin
        check("event", {ev_ext, ev_break, ev_code}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rx_en", rx_en, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Plain make then break
    ev_ready = 1'b1;
    exp_q.push_back(ev(1'b0, 1'b0, 8'h1C));
    send(8'h1C);
    send(8'hF0);
    exp_q.push_back(ev(1'b0, 1'b1, 8'h1C));
    send(8'h1C);
    wait_drain("drain_plain");
    idle(5);
    check("plain_ovf", ovf, 0);

    // Extended make then extended break
    send(8'hE0);
    exp_q.push_back(ev(1'b1, 1'b0, 8'h75));
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    exp_q.push_back(ev(1'b1, 1'b1, 8'h75));
    send(8'h75);
    wait_drain("drain_ext");
    idle(3);

    // Fill, overflow, drain, clear
    ev_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(ev(1'b0, 1'b0, 8'(i)));
      send(8'(i));
      if (i == 3) check("rx_en_at3", rx_en, 1);
      if (i == 4) check("rx_en_full", rx_en, 0);
    end
    check("ovf_set", ovf, 1);
    check("ovf_valid", ev_valid, 1);
    ev_ready = 1'b1;
    wait_drain("drain_ovf");
    check("rx_en_drained", rx_en, 1);
    check("ovf_sticky", ovf, 1);
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Full FIFO, final byte lands together with a pop
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ev(1'b0, 1'b0, 8'h11 + 8'(i)));
      send(8'h11 + 8'(i));
    end
    check("full_rx_en", rx_en, 0);
    @(posedge clk); #1;
    exp_q.push_back(ev(1'b0, 1'b0, 8'h15));
    ev_ready     = 1'b1;
    rx_done_tick = 1'b1;
    rx_dout      = 8'h15;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    ev_ready     = 1'b0;
    check("simul_ovf", ovf, 0);
    check("simul_count4", rx_en, 0);
    ev_ready = 1'b1;
    wait_drain("drain_simul");
    check("simul_ovf_after", ovf, 0);

    // Prefix followed by a long gap
    send(8'hE0);
    idle(20);
`ifdef PS2_KB_TIMEOUT_EN
    exp_q.push_back(ev(1'b0, 1'b0, 8'h1C));
`else
    exp_q.push_back(ev(1'b1, 1'b0, 8'h1C));
`endif
    send(8'h1C);
    wait_drain("drain_timeout");

    // Reset in the middle of a break sequence with an event buffered
    ev_ready = 1'b0;
    send(8'h2A);
    check("pre_rst_valid", ev_valid, 1);
    send(8'hF0);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", ev_valid, 0);
    check("mid_rst_rx_en", rx_en, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    ev_ready = 1'b1;
    exp_q.push_back(ev(1'b0, 1'b0, 8'h1C));
    send(8'h1C);
    wait_drain("drain_reset");
    idle(5);
    check("final_ovf", ovf, 0);
    check("final_valid", ev_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_kb_ctrl.md
Name: ps2_kb_ctrl

Overview:
- Keyboard-side sequencer sitting directly behind the PS/2 receiver.
- Drives the receiver's rx_en and consumes its rx_done_tick and 8-bit data byte.
- Assembles scan-code sequences (plain, F0 break, E0 extended, E0 F0 extended break) into single key events.
- Buffers events in a small FIFO with a valid/ready handshake toward the consumer (UI/text logic).

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2.
FIFO_AW, 2, log2(FIFO_DEPTH).
TIMEOUT_CYC, 100000, clk cycles allowed between a prefix byte and its final code (2 ms at 50 MHz).

Ports:
clk  in  1  system clock; every register is rising-edge.
reset  in  1  asynchronous, active-high reset.
rx_done_tick  in  1  one-cycle strobe from the receiver; rx_dout is valid in that cycle.
rx_dout  in  8  received byte.
rx_en  out  1  receive enable to the receiver; combinational, 1 when FIFO count < FIFO_DEPTH.
ev_valid  out  1  FIFO not empty.
ev_ready  in  1  consumer accepts the head event when ev_valid & ev_ready.
ev_code  out  8  scan code of the head event.
ev_break  out  1  head event is a key release.
ev_ext  out  1  head event carried the E0 prefix.
ovf  out  1  sticky flag: an event was dropped because the FIFO was full.
ovf_clr  in  1  clears ovf; set has priority if both happen in the same cycle.

Behaviour:
- Reset values: state=IDLE, ext_reg=0, brk_reg=0, FIFO empty, ev_valid=0, ovf=0, timeout counter=0, rx_en=1. ev_code/ev_break/ev_ext show FIFO entry 0; their content is don't-care while ev_valid=0.
- Bytes are acted on only in cycles where rx_done_tick=1. Otherwise the FSM holds, except for the timeout.
- FSM states: IDLE, GOT_E0, GOT_F0.
  - IDLE: E0 -> GOT_E0, ext_reg=1. F0 -> GOT_F0, brk_reg=1. Any other byte -> push {ext=0, brk=0, code}, stay IDLE.
  - GOT_E0: F0 -> GOT_F0, brk_reg=1, ext_reg kept. E0 -> stay, ext_reg=1. Other byte -> push {1, 0, code} -> IDLE.
  - GOT_F0: F0 -> stay. E0 (protocol error) -> GOT_E0 with ext_reg=1, brk_reg=0. Other byte -> push {ext_reg, 1, code} -> IDLE.
- Every transition to IDLE clears ext_reg and brk_reg.
- Timeout counter: cleared on any rx_done_tick and while in IDLE; increments each cycle in GOT_E0/GOT_F0. On reaching TIMEOUT_CYC-1, go to IDLE, clear flags and counter; no event is pushed.
- Push latency: the event is in the FIFO and ev_valid=1 on the cycle after the final rx_done_tick. It is visible at the outputs if the FIFO was empty.
- FIFO: pop = ev_valid & ev_ready. Push accepted when count < FIFO_DEPTH, or when the FIFO is full and a pop occurs in the same cycle. Otherwise the event is dropped and ovf is set.
  - Simultaneous push and pop on a non-empty FIFO leaves count unchanged.
  - Pointers are FIFO_AW bits, wrap modulo FIFO_DEPTH; count is FIFO_AW+1 bits.
- rx_en deasserts as soon as count == FIFO_DEPTH. A frame already in progress still completes, and can therefore cause an overflow.
- Reset mid-sequence discards prefix state and all buffered events.

Optional Feature:
- Macro: PS2_KB_TIMEOUT_EN.
- Defined: the timeout counter and the forced return to IDLE are built as described above.
- Undefined: no counter is built, TIMEOUT_CYC is unused, and prefix states wait indefinitely for the next byte.

Decomposition:
- Package ps2_kb_pkg holds:
  - byte constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0;
  - state encoding IDLE=2'b00, GOT_E0=2'b01, GOT_F0=2'b10;
  - EV_W=10 and the event field order {ext, brk, code[7:0]}.
- One sub-module, ps2_kb_fifo: synchronous FIFO, width EV_W, depth FIFO_DEPTH, with push/pop/full/empty/count.
- The FSM, timeout and ovf logic stay in the top module.

Test Plan:
- Bytes 1C, F0, 1C with ev_ready=1 -> events {0,0,1C} then {0,1,1C}; no extra events; ovf=0.
- Bytes E0, 75, E0, F0, 75 -> events {1,0,75} then {1,1,75}.
- ev_ready=0, five plain codes 01..05 with FIFO_DEPTH=4 -> rx_en=0 after the fourth; fifth dropped; ovf=1. Drain gives 01..04 in order and rx_en returns to 1. Pulse ovf_clr -> ovf=0.
- FIFO full, final byte strobe in the same cycle as ev_ready=1 -> new event accepted, ovf stays 0, count stays 4.
- With PS2_KB_TIMEOUT_EN and TIMEOUT_CYC=16: E0, wait 20 cycles, then 1C -> single event {0,0,1C}. Without the macro -> {1,0,1C}.
- Assert reset for one cycle after an F0 byte, then send 1C -> event {0,0,1C}; ev_valid low immediately during reset.
